// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: operand forward selects and
// hazard FSM states, also imported by the ID stage.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } hz_state_t;

  // EX wins over MEM; x0 and loads in EX never forward.
  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] ex_rd,
    input logic       ex_we,
    input logic       ex_ld,
    input logic [4:0] mem_rd,
    input logic       mem_we
  );
    logic live;
    live = used && (rs != 5'd0);
    if (live && ex_we && !ex_ld && (ex_rd == rs))
      fwd_sel = FWD_EX;
    else if (live && mem_we && (mem_rd == rs))
      fwd_sel = FWD_MEM;
    else
      fwd_sel = FWD_REG;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding,
// load-use stalls, memory wait freezes and branch flush sequencing.
module hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_addr_i,
  input  logic [4:0]       ID_rs2_addr_i,
  input  logic             ID_rs1_used_i,
  input  logic             ID_rs2_used_i,
  input  logic             ID_branch_en_i,
  input  logic [4:0]       EX_rd_addr_i,
  input  logic             EX_rd_wr_en_i,
  input  logic             EX_is_load_i,
  input  logic [4:0]       MEM_rd_addr_i,
  input  logic             MEM_rd_wr_en_i,
  input  logic             MEM_req_i,
  input  logic             MEM_ready_i,
  output logic             IF_stall_o,
  output logic             ID_stall_o,
  output logic             ID_flush_o,
  output logic             EX_bubble_o,
  output logic             EX_hold_o,
  output logic             MEM_hold_o,
  output logic [1:0]       forward_reg1_o,
  output logic [1:0]       forward_reg2_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_timeout_o
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  hz_state_t state_q, state_d;
  logic      flush_q, flush_d;
  logic      tmo_q, tmo_d;
  logic [TW-1:0] wcnt_q, wcnt_d;

  logic mem_wait;
  logic lu1, lu2;
  logic load_use;
  logic stall;
  logic branch_acc;

  assign mem_wait = MEM_req_i && !MEM_ready_i;

  assign lu1 = ID_rs1_used_i && (ID_rs1_addr_i != 5'd0)
            && EX_rd_wr_en_i && EX_is_load_i
            && (EX_rd_addr_i == ID_rs1_addr_i);
  assign lu2 = ID_rs2_used_i && (ID_rs2_addr_i != 5'd0)
            && EX_rd_wr_en_i && EX_is_load_i
            && (EX_rd_addr_i == ID_rs2_addr_i);

  assign load_use   = (lu1 || lu2) && !mem_wait;
  assign stall      = mem_wait || load_use;
  assign branch_acc = ID_branch_en_i && !stall;

  // A pending flush survives until ID actually advances.
  assign flush_d = branch_acc || (flush_q && stall);

  always_comb begin
    state_d = RUN;
    unique case (1'b1)
      mem_wait:              state_d = MEM_WAIT;
      branch_acc:            state_d = FLUSH;
      (flush_q && load_use): state_d = FLUSH;
      default:               state_d = RUN;
    endcase
  end

  always_comb begin
    wcnt_d = '0;
    if (mem_wait) begin
      if (state_q != MEM_WAIT)
        wcnt_d = TW'(1);
      else if (wcnt_q != TW'(MEM_TIMEOUT))
        wcnt_d = wcnt_q + 1'b1;
      else
        wcnt_d = wcnt_q;
    end
  end

  assign tmo_d = tmo_q || (wcnt_d == TW'(MEM_TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      flush_q <= 1'b0;
      tmo_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      tmo_q   <= tmo_d;
      wcnt_q  <= wcnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (branch_acc),
    .cnt_o (flush_cnt_o)
  );

  // Combinational outputs are forced idle while reset is held.
  assign IF_stall_o  = rst_i && stall;
  assign ID_stall_o  = rst_i && stall;
  assign EX_bubble_o = rst_i && load_use;
  assign EX_hold_o   = rst_i && mem_wait;
  assign MEM_hold_o  = rst_i && mem_wait;

  assign forward_reg1_o = !rst_i ? FWD_REG :
    fwd_sel(ID_rs1_used_i, ID_rs1_addr_i, EX_rd_addr_i,
            EX_rd_wr_en_i, EX_is_load_i, MEM_rd_addr_i,
            MEM_rd_wr_en_i);
  assign forward_reg2_o = !rst_i ? FWD_REG :
    fwd_sel(ID_rs2_used_i, ID_rs2_addr_i, EX_rd_addr_i,
            EX_rd_wr_en_i, EX_is_load_i, MEM_rd_addr_i,
            MEM_rd_wr_en_i);

  assign ID_flush_o    = flush_q;
  assign mem_timeout_o = tmo_q;

endmodule
